// File: rtl/alu_md_pkg.sv
// Shared constants for the ALU control / multiply-divide block: ALUctl codes,
// R-type function codes, ALUop classes and the sequencer state encoding.
package alu_md_pkg;

    // ALUctl operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_BEQ = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    // Main-decoder op classes
    localparam logic [1:0] OP_MEM = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // R-type function codes
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // Sequencer state encoding
    typedef logic [2:0] md_state_t;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // mult/multu/div/divu all share the 0110xx pattern
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide datapath: one shift-add (multiply) or restoring
// shift-subtract (divide) iteration per step. Operands are reduced to
// magnitudes at load; the signed correction is applied combinationally on the
// result outputs so they are final while the controller sits in FIX.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    output logic             last_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // acc: product high half / partial remainder; sh: multiplier / quotient
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             dz_q, dz_d;
    logic             neg_pq_q, neg_pq_d;
    logic             neg_r_q, neg_r_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] trial;
    logic [2*WIDTH-1:0] prod, prod_f;
    logic [WIDTH-1:0] quo_f, rem_f;

    assign sign_a  = is_signed_i & a_i[WIDTH-1];
    assign sign_b  = is_signed_i & b_i[WIDTH-1];
    assign mag_a   = sign_a ? (~a_i + 1'b1) : a_i;
    assign mag_b   = sign_b ? (~b_i + 1'b1) : b_i;

    assign sum     = {1'b0, acc_q} + (sh_q[0] ? {1'b0, op_q} : '0);
    assign shifted = {acc_q, sh_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, op_q};
    assign trial   = WIDTH'(shifted - {1'b0, op_q});

    assign last_o  = cnt_q == LAST_CNT;

    // Next-state: capture operands on load, otherwise iterate while stepping
    always_comb begin
        acc_d    = acc_q;
        sh_d     = sh_q;
        op_d     = op_q;
        a_raw_d  = a_raw_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        dz_d     = dz_q;
        neg_pq_d = neg_pq_q;
        neg_r_d  = neg_r_q;
        if (load_i) begin
            acc_d    = '0;
            sh_d     = mag_a;
            op_d     = mag_b;
            a_raw_d  = a_i;
            cnt_d    = '0;
            div_d    = is_div_i;
            dz_d     = is_div_i && (b_i == '0);
            neg_pq_d = sign_a ^ sign_b;
            neg_r_d  = sign_a;
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
                acc_d = ge ? trial : shifted[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], ge};
            end else begin
                acc_d = sum[WIDTH:1];
                sh_d  = {sum[0], sh_q[WIDTH-1:1]};
            end
        end
    end

    // Datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            sh_q     <= '0;
            op_q     <= '0;
            a_raw_q  <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            dz_q     <= 1'b0;
            neg_pq_q <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            op_q     <= op_d;
            a_raw_q  <= a_raw_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dz_q     <= dz_d;
            neg_pq_q <= neg_pq_d;
            neg_r_q  <= neg_r_d;
        end
    end

    assign prod   = {acc_q, sh_q};
    assign prod_f = neg_pq_q ? (~prod + 1'b1) : prod;
    assign quo_f  = neg_pq_q ? (~sh_q + 1'b1) : sh_q;
    assign rem_f  = neg_r_q ? (~acc_q + 1'b1) : acc_q;

    // Final result selection with sign correction; divide-by-zero is a fixed pattern
    always_comb begin
        res_hi_o = prod_f[2*WIDTH-1:WIDTH];
        res_lo_o = prod_f[WIDTH-1:0];
        if (dz_q) begin
            res_hi_o = a_raw_q;
            res_lo_o = '1;
        end else if (div_q) begin
            res_hi_o = rem_f;
            res_lo_o = quo_f;
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// ALU control decoder plus HI/LO register file and multiply/divide sequencer.
// Optional build macro ALU_MD_SIGNED_EN: mult/div operate on two's-complement
// operands; without it they behave as multu/divu.
// Handshake: a mul/div start is accepted only when valid, ALUop=R, a mul/div
// func and the sequencer is IDLE; there is no queueing, so the pipeline holds
// the instruction while busy is high and re-issues it afterwards.
module alu_control_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       func,
    input  logic [1:0]       ALUop,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       ALUctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mdout
);

    md_state_t        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             rtype_v;
    logic             idle;
    logic             start;
    logic             is_div;
    logic             signed_req;
    logic             div_zero;
    logic             last;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign rtype_v  = valid && (ALUop == OP_R);
    assign idle     = state_q == ST_IDLE;
    assign start    = rtype_v && is_muldiv(func) && idle;
    assign is_div   = func[1];
    assign div_zero = is_div && (b == '0);

`ifdef ALU_MD_SIGNED_EN
    assign signed_req = ~func[0];
`else
    assign signed_req = 1'b0;
`endif

    // Single-cycle ALU operation decode
    always_comb begin
        ALUctl = ALU_BAD;
        case (ALUop)
            OP_MEM: ALUctl = ALU_ADD;
            OP_BR:  ALUctl = ALU_BEQ;
            OP_R: begin
                case (func)
                    F_AND:   ALUctl = ALU_AND;
                    F_OR:    ALUctl = ALU_OR;
                    F_ADD:   ALUctl = ALU_ADD;
                    F_SUB:   ALUctl = ALU_SUB;
                    F_SLT:   ALUctl = ALU_SLT;
                    F_NOR:   ALUctl = ALU_NOR;
                    default: ALUctl = ALU_BAD;
                endcase
            end
            default: ALUctl = ALU_BAD;
        endcase
    end

    // Sequencer next state; divide by zero bypasses the iteration phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (div_zero)    state_d = ST_FIX;
                    else if (is_div) state_d = ST_DIV;
                    else             state_d = ST_MUL;
                end
            end
            ST_MUL:  if (last) state_d = ST_FIX;
            ST_DIV:  if (last) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // HI/LO next value: result write on leaving FIX, mthi/mtlo only when idle
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == ST_FIX) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (rtype_v && idle) begin
            if (func == F_MTHI) hi_d = a;
            if (func == F_MTLO) lo_d = a;
        end
    end

    // State and HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    muldiv_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .load_i      (start),
        .is_div_i    (is_div),
        .is_signed_i (signed_req),
        .a_i         (a),
        .b_i         (b),
        .step_i      ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .last_o      (last),
        .res_hi_o    (res_hi),
        .res_lo_o    (res_lo)
    );

    assign busy = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
    assign done = state_q == ST_DONE;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // mfhi/mflo read port
    always_comb begin
        mdout = '0;
        if (ALUop == OP_R) begin
            if (func == F_MFHI)      mdout = hi_q;
            else if (func == F_MFLO) mdout = lo_q;
        end
    end

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md (WIDTH=32).
module tb_alu_control_md;

    logic        clk;
    logic        rst;
    logic [5:0]  func;
    logic [1:0]  ALUop;
    logic        valid;
    logic [31:0] a, b;
    logic [3:0]  ALUctl;
    logic        busy, done;
    logic [31:0] hi, lo, mdout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_hi, m_lo;
    logic [63:0] exp_q[$];

    alu_control_md #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .func   (func),
        .ALUop  (ALUop),
        .valid  (valid),
        .a      (a),
        .b      (b),
        .ALUctl (ALUctl),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .mdout  (mdout)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic ctl_vec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] exp, input string tag);
        @(negedge clk);
        valid = 1'b0; ALUop = op; func = f;
        #1;
        check(tag, ALUctl, exp);
    endtask

    task automatic mt_op(input logic v, input logic [5:0] f, input logic [31:0] val);
        @(negedge clk);
        valid = v; ALUop = 2'b10; func = f; a = val;
        @(posedge clk); #1;
        valid = 1'b0; func = 6'd0;
        if (v && f == 6'b010001) m_hi = val;
        if (v && f == 6'b010011) m_lo = val;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    // Issue one mul/div, optionally injecting an mthi and a second start while busy
    task automatic run_md(input bit no_wait, input bit inject, input string tag,
                          input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        int n;
        logic [63:0] want;
        exp_q.push_back({ehi, elo});
        if (!no_wait) @(negedge clk);
        valid = 1'b1; ALUop = 2'b10; func = f; a = av; b = bv;
        @(posedge clk); #1;
        n = 1;
        check({tag, "_busy"}, busy, 1'b1);
        while (!done && n < elat + 10) begin
            if (n == elat - 1) begin
                check({tag, "_hold_hi"}, hi, m_hi);
                check({tag, "_hold_lo"}, lo, m_lo);
            end
            if (inject && n == 3) begin
                valid = 1'b1; func = 6'b010001; a = 32'hDEADBEEF;
            end else if (inject && n == 4) begin
                valid = 1'b1; func = 6'b011011; a = 32'd100; b = 32'd7;
            end else begin
                valid = 1'b0; func = 6'd0; a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            n++;
        end
        valid = 1'b0; func = 6'd0;
        check({tag, "_latency"}, n, elat);
        want = exp_q.pop_front();
        check({tag, "_result"}, {hi, lo}, want);
        check({tag, "_busy_in_done"}, busy, 1'b0);
        m_hi = ehi; m_lo = elo;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1; valid = 1'b0; ALUop = 2'b00; func = 6'd0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // ALU control decode
        ctl_vec(2'b00, 6'b101010, 4'b0010, "ctl_lwsw");
        ctl_vec(2'b01, 6'b100000, 4'b0011, "ctl_branch");
        ctl_vec(2'b11, 6'b100000, 4'b1111, "ctl_reserved");
        ctl_vec(2'b10, 6'b100100, 4'b0000, "ctl_and");
        ctl_vec(2'b10, 6'b100101, 4'b0001, "ctl_or");
        ctl_vec(2'b10, 6'b100000, 4'b0010, "ctl_add");
        ctl_vec(2'b10, 6'b100010, 4'b0110, "ctl_sub");
        ctl_vec(2'b10, 6'b101010, 4'b0111, "ctl_slt");
        ctl_vec(2'b10, 6'b100111, 4'b1100, "ctl_nor");
        ctl_vec(2'b10, 6'b000000, 4'b1111, "ctl_unknown");
        ctl_vec(2'b10, 6'b011000, 4'b1111, "ctl_mult");

        // HI/LO moves and reads
        mt_op(1'b1, 6'b010001, 32'h12345678);
        mt_op(1'b1, 6'b010011, 32'h9ABCDEF0);
        mt_op(1'b0, 6'b010001, 32'h11111111);
        @(negedge clk);
        ALUop = 2'b10; func = 6'b010000; #1; check("mfhi", mdout, 32'h12345678);
        func = 6'b010010; #1; check("mflo", mdout, 32'h9ABCDEF0);
        func = 6'b100000; #1; check("mdout_other", mdout, 32'd0);

        // Multiply / divide
        run_md(1'b0, 1'b0, "multu_max", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
        run_md(1'b0, 1'b0, "divu_100_7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        run_md(1'b0, 1'b0, "divu_by0", 6'b011011, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 2);
        run_md(1'b0, 1'b0, "multu_shift", 6'b011001, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 34);
        run_md(1'b0, 1'b0, "divu_by1", 6'b011011, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 34);
`ifdef ALU_MD_SIGNED_EN
        run_md(1'b0, 1'b0, "mult_neg", 6'b011000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34);
        run_md(1'b0, 1'b0, "div_neg", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
`else
        run_md(1'b0, 1'b0, "mult_uns", 6'b011000, 32'hFFFFFFFD, 32'd5, 32'h4, 32'hFFFFFFF1, 34);
        run_md(1'b0, 1'b0, "div_uns", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 34);
`endif
        run_md(1'b0, 1'b1, "busy_ignore", 6'b011001, 32'd3, 32'd5, 32'd0, 32'd15, 34);
        mt_op(1'b1, 6'b010001, 32'hCAFEF00D);

        // Reset in the middle of a sequence
        @(negedge clk);
        valid = 1'b1; ALUop = 2'b10; func = 6'b011001; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        valid = 1'b0; func = 6'd0;
        n = 1;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        m_hi = '0; m_lo = '0;
        #1;
        rst = 1'b0;
        run_md(1'b1, 1'b0, "after_rst", 6'b011001, 32'd6, 32'd7, 32'd0, 32'd42, 34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
